// File: rtl/bin_to_dec_display.sv
// rtl/bin_to_dec_display.sv - serial double-dabble binary to display-code encoder (option: LEADING_ZERO_BLANK_EN)
module bin_to_dec_display #(
    parameter int W      = 16,
    parameter int DIGITS = 4,
    parameter int SIGNED = 1
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [W-1:0]          bin_data,
    input  logic [2:0]            dp,
    output logic [5*DIGITS-1:0]   dec_out,
    output logic [DIGITS-1:0]     point,
    output logic                  of,
    output logic                  busy,
    output logic                  sync
);

    localparam int BCD_DIG = (W * 302) / 1000 + 1;
    localparam int CW      = $clog2(W + DIGITS + 1);

    localparam logic [4:0] C_MINUS = 5'h11;
    localparam logic [4:0] C_O     = 5'h12;
    localparam logic [4:0] C_F     = 5'h13;
    localparam logic [4:0] C_BLANK = 5'h1F;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_FORMAT, S_FIN} state_t;

    state_t                 state;
    state_t                 state_n;
    logic [W-1:0]           data_r;
    logic [W-1:0]           mag;
    logic [2:0]             dp_r;
    logic                   neg;
    logic                   shown;
    logic [4*BCD_DIG-1:0]   bcd;
    logic [4*BCD_DIG-1:0]   bcd_n;
    logic [3:0]             nib;
    logic [CW-1:0]          cnt;
    logic [5*DIGITS-1:0]    shadow;
    logic                   ovf;
    logic [3:0]             cur_nib;
    logic [4:0]             code;
    logic                   blank;
    logic                   sign_wr;
    int                     avail;
    int                     k;

    // State register
    always_ff @(posedge mclk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: SHIFT runs W cycles, FORMAT runs DIGITS cycles counting down
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (en) state_n = S_LOAD;
            S_LOAD:   state_n = S_SHIFT;
            S_SHIFT:  if (cnt == CW'(W - 1)) state_n = S_FORMAT;
            S_FORMAT: if (cnt == '0) state_n = S_FIN;
            S_FIN:    state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next magnitude bit
    always_comb begin
        bcd_n    = '0;
        bcd_n[0] = mag[W-1];
        nib      = '0;
        for (int i = 0; i < BCD_DIG; i++) begin
            nib = bcd[4*i +: 4];
            if (nib >= 4'd5) nib = nib + 4'd3;
            bcd_n[4*i+1 +: 3] = nib[2:0];
            if (i < BCD_DIG - 1) bcd_n[4*i+4] = nib[3];
        end
    end

    // Overflow detect and display code for the position currently being formatted
    always_comb begin
        avail   = DIGITS - (neg ? 1 : 0);
        k       = int'(cnt);
        ovf     = 1'b0;
        cur_nib = 4'd0;
        code    = C_BLANK;
        blank   = 1'b0;
        sign_wr = 1'b0;
        for (int i = 0; i < BCD_DIG; i++) begin
            if (i >= avail && bcd[4*i +: 4] != 4'd0) ovf = 1'b1;
            if (i == k) cur_nib = bcd[4*i +: 4];
        end
        if (ovf) begin
            if (k == 1)              code = C_O;
            else if (k == 0)         code = C_F;
            else if (k == 2 && neg)  code = C_MINUS;
            else                     code = C_BLANK;
        end else begin
`ifdef LEADING_ZERO_BLANK_EN
            // Blank leading zeros above the point; the sign lands just left of the first shown digit
            blank   = !shown && cur_nib == 4'd0 && k > int'(dp_r);
            code    = blank ? C_BLANK : {1'b0, cur_nib};
            sign_wr = neg && !shown && !blank && (k + 1 < DIGITS);
`else
            // Zero-filled display; the sign always takes the leftmost digit
            code    = (neg && k == DIGITS - 1) ? C_MINUS : {1'b0, cur_nib};
`endif
        end
    end

    // Datapath and registered outputs, sequenced by the FSM state
    always_ff @(posedge mclk) begin
        if (rst) begin
            dec_out <= {DIGITS{C_BLANK}};
            point   <= '0;
            of      <= 1'b0;
            busy    <= 1'b0;
            sync    <= 1'b0;
            data_r  <= '0;
            dp_r    <= '0;
            mag     <= '0;
            neg     <= 1'b0;
            bcd     <= '0;
            cnt     <= '0;
            shadow  <= {DIGITS{C_BLANK}};
            shown   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    sync <= 1'b0;
                    if (en) begin
                        data_r <= bin_data;
                        dp_r   <= (int'(dp) < DIGITS) ? dp : 3'd0;
                        busy   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    neg    <= (SIGNED != 0) && data_r[W-1];
                    mag    <= ((SIGNED != 0) && data_r[W-1]) ? (~data_r + W'(1)) : data_r;
                    bcd    <= '0;
                    cnt    <= '0;
                    shadow <= {DIGITS{C_BLANK}};
                    shown  <= 1'b0;
                end
                S_SHIFT: begin
                    bcd <= bcd_n;
                    mag <= {mag[W-2:0], 1'b0};
                    if (cnt == CW'(W - 1)) cnt <= CW'(DIGITS - 1);
                    else                   cnt <= cnt + CW'(1);
                end
                S_FORMAT: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (i == k)               shadow[5*i +: 5] <= code;
                        if (sign_wr && i == k + 1) shadow[5*i +: 5] <= C_MINUS;
                    end
                    shown <= shown | ~blank;
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                S_FIN: begin
                    dec_out <= shadow;
                    point   <= (ovf || dp_r == 3'd0) ? '0
                               : ({{(DIGITS-1){1'b0}}, 1'b1} << dp_r);
                    of      <= ovf;
                    sync    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
